// File: rtl/module_result_display.sv
// Result display stage: latches quotient/remainder, converts both to BCD with a
// sequential double-dabble and drives a 4-digit multiplexed 7-segment display.
module module_result_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Q,
  input  logic [4:0] R,
  input  logic       valid,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned OP_W      = 5;
  localparam int unsigned BCD_W     = 8;
  localparam int unsigned DIG_W     = 4;
  localparam int unsigned NUM_DIG   = 4;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned STEP_LAST = OP_W - 1;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [DIG_W-1:0] BLANK     = 4'hF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [OP_W-1:0]                 q_sh_q, q_sh_d;
  logic [OP_W-1:0]                 r_sh_q, r_sh_d;
  logic [BCD_W-1:0]                q_bcd_q, q_bcd_d;
  logic [BCD_W-1:0]                r_bcd_q, r_bcd_d;
  logic [STEP_W-1:0]               step_q, step_d;
  logic                            busy_q, busy_d;
  logic [NUM_DIG-1:0][DIG_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIG-1:0]              an_q, an_d;
  logic [SEG_W-1:0]                seg_q, seg_d;

  // One double-dabble step: correct nibbles >= 5, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                               input logic             in_bit);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    return {adj[BCD_W-2:0], in_bit};
  endfunction

  function automatic logic [DIG_W-1:0] tens_code(input logic [DIG_W-1:0] t);
    logic [DIG_W-1:0] code;
    code = t;
    if ((t == 4'd0) && (BLANK_LZ != 0)) code = BLANK;
    return code;
  endfunction

  function automatic logic [SEG_W-1:0] decode(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Conversion FSM: capture on valid, five dabble steps, then commit digits.
  always_comb begin
    state_d = state_q;
    q_sh_d  = q_sh_q;
    r_sh_d  = r_sh_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    step_d  = step_q;
    busy_d  = 1'b0;
    dig_d   = dig_q;

    case (state_q)
      IDLE: begin
        if (valid) begin
          q_sh_d  = {1'b0, Q};
          r_sh_d  = R;
          q_bcd_d = '0;
          r_bcd_d = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        q_bcd_d = dd_step(q_bcd_q, q_sh_q[OP_W-1]);
        r_bcd_d = dd_step(r_bcd_q, r_sh_q[OP_W-1]);
        q_sh_d  = {q_sh_q[OP_W-2:0], 1'b0};
        r_sh_d  = {r_sh_q[OP_W-2:0], 1'b0};
        step_d  = step_q + STEP_W'(1);
        busy_d  = 1'b1;
        if (step_q == STEP_W'(STEP_LAST)) begin
          dig_d[3] = tens_code(q_bcd_d[7:4]);
          dig_d[2] = q_bcd_d[3:0];
          dig_d[1] = tens_code(r_bcd_d[7:4]);
          dig_d[0] = r_bcd_d[3:0];
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan; decoding uses the digit values committed this edge.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
    an_d  = ~(NUM_DIG'(1) << idx_d);
    seg_d = decode(dig_d[idx_d]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_sh_q  <= '0;
      r_sh_q  <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      dig_q   <= {NUM_DIG{BLANK}};
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      r_sh_q  <= r_sh_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
